// File: rtl/ga_seq_arbiter.sv
// Master phase sequencer and DRAM bus arbiter: Johnson phase vector, derived clocks,
// RAS_N windows and CPU/video slot arbitration. Optional S-code recovery: SEQ_RECOVERY_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no CPU access pending, READY=1, video address on the mux
// WAIT    | request seen, stalling the Z80 until the CPU window opens
// GRANT   | CPU owns the RAS_N window, CPU address on the mux
// HOLD    | access done, waiting for MREQ_N to rise before re-arming

module ga_seq_arbiter #(
   parameter int VID_RAS_START = 2,
   parameter int CPU_RAS_START = 10,
   parameter int RAS_LEN       = 4
) (
   input  logic       clk_16,
   input  logic       RESET_N,
   input  logic       MREQ_N,
   output logic [7:0] S,
   output logic       PHI_N,
   output logic       CCLK,
   output logic       RAS_N,
   output logic       READY,
   output logic       CPU_SEL,
   output logic       VID_LD0,
   output logic       VID_LD1,
   output logic       SEQ_ERR
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_GRANT,
      ST_HOLD
   } state_t;

   localparam logic [3:0] VID_P    = 4'(VID_RAS_START);
   localparam logic [3:0] CPU_P    = 4'(CPU_RAS_START);
   localparam logic [3:0] LEN_P    = 4'(RAS_LEN);
   localparam logic [3:0] LD0_P    = 4'(VID_RAS_START + RAS_LEN - 2);
   localparam logic [3:0] LD1_P    = 4'(VID_RAS_START + RAS_LEN - 1);
   localparam logic [2:0] CNT_LOAD = 3'(RAS_LEN - 1);

   // Johnson code -> phase index: ones count on the rising half, 16 - ones on the falling half.
   function automatic logic [3:0] phase_of(input logic [7:0] code);
      logic [3:0] ones;
      ones = 4'd0;
      for (int i = 0; i < 8; i++) begin
         ones = ones + {3'b000, code[i]};
      end
      return code[7] ? (4'd0 - ones) : ones;
   endfunction

`ifdef SEQ_RECOVERY_EN
   function automatic logic [7:0] code_of(input logic [3:0] p);
      return p[3] ? (8'hFF << p[2:0]) : ~(8'hFF << p[2:0]);
   endfunction

   logic seq_bad;
`endif

   state_t     state_q, state_nxt;
   logic [2:0] cnt_q, cnt_nxt;
   logic [7:0] s_nxt;
   logic [3:0] p_nxt;
   logic       in_vid, in_cpu;

   always_comb begin
      s_nxt = {S[6:0], ~S[7]};
`ifdef SEQ_RECOVERY_EN
      seq_bad = 1'b0;
      if (S != code_of(phase_of(S))) begin
         seq_bad = 1'b1;
         s_nxt   = 8'h00;
      end
`endif
   end

   // All registered outputs describe the phase being entered, so decode the next code.
   assign p_nxt  = phase_of(s_nxt);
   assign in_vid = (4'(p_nxt - VID_P) < LEN_P);
   assign in_cpu = (4'(p_nxt - CPU_P) < LEN_P);

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (!MREQ_N) begin
               if (p_nxt == CPU_P) begin
                  state_nxt = ST_GRANT;
                  cnt_nxt   = CNT_LOAD;
               end else begin
                  state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (MREQ_N) begin
               state_nxt = ST_IDLE;
            end else if (p_nxt == CPU_P) begin
               state_nxt = ST_GRANT;
               cnt_nxt   = CNT_LOAD;
            end
         end
         ST_GRANT: begin
            if (cnt_q == 3'd0) begin
               state_nxt = MREQ_N ? ST_IDLE : ST_HOLD;
            end else begin
               cnt_nxt = cnt_q - 3'd1;
            end
         end
         ST_HOLD: begin
            if (MREQ_N) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
`ifdef SEQ_RECOVERY_EN
      if (seq_bad) begin
         state_nxt = ST_IDLE;
         cnt_nxt   = 3'd0;
      end
`endif
   end

   always_ff @(posedge clk_16 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
         S       <= 8'h00;
         PHI_N   <= 1'b1;
         CCLK    <= 1'b0;
         RAS_N   <= 1'b1;
         READY   <= 1'b1;
         CPU_SEL <= 1'b0;
         VID_LD0 <= 1'b0;
         VID_LD1 <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         S       <= s_nxt;
         PHI_N   <= ~p_nxt[1];
         CCLK    <= p_nxt[3];
         RAS_N   <= ~(in_vid | in_cpu);
         READY   <= (state_nxt != ST_WAIT);
         CPU_SEL <= (state_nxt == ST_GRANT);
         VID_LD0 <= (p_nxt == LD0_P);
         VID_LD1 <= (p_nxt == LD1_P);
      end
   end

`ifdef SEQ_RECOVERY_EN
   always_ff @(posedge clk_16 or negedge RESET_N) begin
      if (!RESET_N) begin
         SEQ_ERR <= 1'b0;
      end else begin
         SEQ_ERR <= seq_bad;
      end
   end
`else
   assign SEQ_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_ga_seq_arbiter.sv
// Directed bench for ga_seq_arbiter (default parameters, recovery feature not built).
// A local phase counter tracks the expected phase; outputs are sampled on the falling edge.

module tb_ga_seq_arbiter;

   logic       clk_16 = 1'b0;
   logic       RESET_N;
   logic       MREQ_N;
   logic [7:0] S;
   logic       PHI_N, CCLK, RAS_N, READY, CPU_SEL, VID_LD0, VID_LD1, SEQ_ERR;

   int         checks = 0;
   int         passes = 0;
   logic [3:0] tb_p;
   logic [7:0] jc [16] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                           8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

   ga_seq_arbiter dut (
      .clk_16 (clk_16),
      .RESET_N(RESET_N),
      .MREQ_N (MREQ_N),
      .S      (S),
      .PHI_N  (PHI_N),
      .CCLK   (CCLK),
      .RAS_N  (RAS_N),
      .READY  (READY),
      .CPU_SEL(CPU_SEL),
      .VID_LD0(VID_LD0),
      .VID_LD1(VID_LD1),
      .SEQ_ERR(SEQ_ERR)
   );

   always #5 clk_16 = ~clk_16;

   always @(posedge clk_16 or negedge RESET_N) begin
      if (!RESET_N) tb_p <= 4'd0;
      else          tb_p <= tb_p + 4'd1;
   end

   task automatic to_phase(input logic [3:0] k);
      int n;
      n = 0;
      do begin
         @(negedge clk_16);
         n++;
      end while (tb_p != k && n < 40);
   endtask

   task automatic check_reset_values(input string tag);
      checks++;
      if ({S, PHI_N, CCLK, RAS_N, READY, CPU_SEL, VID_LD0, VID_LD1, SEQ_ERR} !== {8'h00, 8'b1011_0000})
         $display("FAIL %s: got S=%h PHI_N=%b CCLK=%b RAS_N=%b READY=%b CPU_SEL=%b LD0=%b LD1=%b ERR=%b want S=00 1 0 1 1 0 0 0 0",
                  tag, S, PHI_N, CCLK, RAS_N, READY, CPU_SEL, VID_LD0, VID_LD1, SEQ_ERR);
      else passes++;
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      MREQ_N  = 1'b1;
      repeat (3) @(negedge clk_16);
      check_reset_values("reset_values");
      RESET_N = 1'b1;
   endtask

   task automatic test_phase_walk();
      for (int i = 0; i < 32; i++) begin
         @(negedge clk_16);
         checks++;
         if (S !== jc[tb_p]) $display("FAIL walk_s p=%0d: got %h want %h", tb_p, S, jc[tb_p]);
         else passes++;
         checks++;
         if (CCLK !== (tb_p >= 4'd8)) $display("FAIL walk_cclk p=%0d: got %b want %b", tb_p, CCLK, (tb_p >= 4'd8));
         else passes++;
         checks++;
         if (PHI_N !== ((tb_p % 4) < 2)) $display("FAIL walk_phi_n p=%0d: got %b want %b", tb_p, PHI_N, ((tb_p % 4) < 2));
         else passes++;
         checks++;
         if (SEQ_ERR !== 1'b0) $display("FAIL walk_seq_err p=%0d: got %b want 0", tb_p, SEQ_ERR);
         else passes++;
      end
   endtask

   task automatic test_ras_video();
      logic exp_ras;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk_16);
         exp_ras = !((tb_p >= 4'd2 && tb_p <= 4'd5) || (tb_p >= 4'd10 && tb_p <= 4'd13));
         checks++;
         if (RAS_N !== exp_ras) $display("FAIL ras_n p=%0d: got %b want %b", tb_p, RAS_N, exp_ras);
         else passes++;
         checks++;
         if (VID_LD0 !== (tb_p == 4'd4)) $display("FAIL vid_ld0 p=%0d: got %b want %b", tb_p, VID_LD0, (tb_p == 4'd4));
         else passes++;
         checks++;
         if (VID_LD1 !== (tb_p == 4'd5)) $display("FAIL vid_ld1 p=%0d: got %b want %b", tb_p, VID_LD1, (tb_p == 4'd5));
         else passes++;
         checks++;
         if ({CPU_SEL, READY} !== 2'b01) $display("FAIL idle_sel_ready p=%0d: got %b%b want 01", tb_p, CPU_SEL, READY);
         else passes++;
      end
   endtask

   task automatic test_cpu_wait();
      logic exp_ready, exp_sel;
      to_phase(4'd3);
      MREQ_N = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk_16);
         exp_ready = !(tb_p >= 4'd4 && tb_p <= 4'd9);
         exp_sel   = (tb_p >= 4'd10 && tb_p <= 4'd13);
         checks++;
         if (READY !== exp_ready) $display("FAIL wait_ready p=%0d: got %b want %b", tb_p, READY, exp_ready);
         else passes++;
         checks++;
         if (CPU_SEL !== exp_sel) $display("FAIL wait_cpu_sel p=%0d: got %b want %b", tb_p, CPU_SEL, exp_sel);
         else passes++;
         if (tb_p == 4'd14) MREQ_N = 1'b1;
      end
   endtask

   task automatic test_direct_grant();
      to_phase(4'd9);
      MREQ_N = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_16);
         checks++;
         if (READY !== 1'b1) $display("FAIL direct_ready p=%0d: got %b want 1", tb_p, READY);
         else passes++;
         checks++;
         if (CPU_SEL !== (tb_p <= 4'd13)) $display("FAIL direct_cpu_sel p=%0d: got %b want %b", tb_p, CPU_SEL, (tb_p <= 4'd13));
         else passes++;
         if (tb_p == 4'd13) MREQ_N = 1'b1;
      end
   endtask

   task automatic test_hold_no_regrant();
      logic exp_ready, exp_sel;
      to_phase(4'd3);
      MREQ_N = 1'b0;
      for (int i = 0; i < 28; i++) begin
         @(negedge clk_16);
         exp_ready = (i >= 12) || !(tb_p >= 4'd4 && tb_p <= 4'd9);
         exp_sel   = (i < 12) && (tb_p >= 4'd10 && tb_p <= 4'd13);
         checks++;
         if (READY !== exp_ready) $display("FAIL hold_ready i=%0d p=%0d: got %b want %b", i, tb_p, READY, exp_ready);
         else passes++;
         checks++;
         if (CPU_SEL !== exp_sel) $display("FAIL hold_cpu_sel i=%0d p=%0d: got %b want %b", i, tb_p, CPU_SEL, exp_sel);
         else passes++;
      end
      MREQ_N = 1'b1;
   endtask

   task automatic test_late_request();
      to_phase(4'd10);
      MREQ_N = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk_16);
         checks++;
         if (READY !== (tb_p == 4'd10)) $display("FAIL late_ready p=%0d: got %b want %b", tb_p, READY, (tb_p == 4'd10));
         else passes++;
         checks++;
         if (CPU_SEL !== (tb_p == 4'd10)) $display("FAIL late_cpu_sel p=%0d: got %b want %b", tb_p, CPU_SEL, (tb_p == 4'd10));
         else passes++;
      end
      MREQ_N = 1'b1;
   endtask

   task automatic test_abort();
      to_phase(4'd5);
      MREQ_N = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_16);
         checks++;
         if (READY !== !(tb_p == 4'd6 || tb_p == 4'd7))
            $display("FAIL abort_ready p=%0d: got %b want %b", tb_p, READY, !(tb_p == 4'd6 || tb_p == 4'd7));
         else passes++;
         checks++;
         if (CPU_SEL !== 1'b0) $display("FAIL abort_cpu_sel p=%0d: got %b want 0", tb_p, CPU_SEL);
         else passes++;
         if (tb_p == 4'd7) MREQ_N = 1'b1;
      end
   endtask

   task automatic test_reset_mid_grant();
      to_phase(4'd9);
      MREQ_N = 1'b0;
      to_phase(4'd11);
      checks++;
      if ({CPU_SEL, RAS_N} !== 2'b10) $display("FAIL midgrant_pre: got sel=%b ras_n=%b want 1 0", CPU_SEL, RAS_N);
      else passes++;
      RESET_N = 1'b0;
      MREQ_N  = 1'b1;
      #1;
      check_reset_values("midgrant_reset");
      repeat (2) @(negedge clk_16);
      RESET_N = 1'b1;
      @(negedge clk_16);
      checks++;
      if ({S, CPU_SEL, READY} !== {8'h01, 2'b01}) $display("FAIL post_reset: got S=%h sel=%b ready=%b want 01 0 1", S, CPU_SEL, READY);
      else passes++;
      to_phase(4'd11);
      checks++;
      if ({S, CPU_SEL, RAS_N} !== {8'hF8, 2'b00}) $display("FAIL post_reset_p11: got S=%h sel=%b ras_n=%b want f8 0 0", S, CPU_SEL, RAS_N);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_phase_walk();
      test_ras_video();
      test_cpu_wait();
      test_direct_grant();
      test_hold_no_regrant();
      test_late_request();
      test_abort();
      test_reset_mid_grant();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
